xorexec_host: RTL

Host-side stream engine for the XOR execution datapath. It sits on the far side of both FIFO interfaces: it pushes a generated byte stream into the input FIFO, drains results from the output FIFO, and reports the result count, a running XOR checksum of the results, and completion or timeout status. It is the counterpart of the FIFO-facing datapath top and serves as the on-chip traffic source/sink and self-test front end.

---
 rtl/xorexec_host_pkg.sv | 19 +
 rtl/xorexec_host_if.sv | 38 +++
 rtl/xorexec_host_wdog.sv | 34 +++
 rtl/xorexec_host.sv | 130 +++++++++++++
 4 files changed

// File: rtl/xorexec_host_pkg.sv
// Shared types and constants for the XOR execution host stream engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xorexec_host_pkg;

    // Transfer sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } host_state_e;

    // Default number of RUN cycles tolerated without a pop.
    localparam int TIMEOUT_DEFAULT = 1024;

    // Width of the transfer length and the tx/rx counters.
    localparam int LEN_W = 8;

endpackage

// File: rtl/xorexec_host_if.sv
// Host-side bundle: command/status plus the push side of the input FIFO and
// the pop side of the output FIFO.
// Latency: n/a. Backpressure: ififo_not_full / ofifo_rdy gate the strobes.
// Ports: master = host engine (drives strobes, data, status),
//        slave  = environment (drives command, FIFO flags, result data).
interface xorexec_host_if #(
    parameter int dwidth = 8
);
    import xorexec_host_pkg::*;

    logic               start;
    logic [LEN_W-1:0]   len;
    logic [dwidth-1:0]  seed;
    logic               busy;
    logic               done;
    logic               error;
    logic               ififo_push;
    logic               ififo_not_full;
    logic [dwidth-1:0]  idata;
    logic               ofifo_pop;
    logic               ofifo_rdy;
    logic [dwidth-1:0]  odata;
    logic [LEN_W-1:0]   rx_count;
    logic [dwidth-1:0]  rx_checksum;

    modport master (
        input  start, len, seed, ififo_not_full, ofifo_rdy, odata,
        output busy, done, error, ififo_push, idata, ofifo_pop,
               rx_count, rx_checksum
    );

    modport slave (
        output start, len, seed, ififo_not_full, ofifo_rdy, odata,
        input  busy, done, error, ififo_push, idata, ofifo_pop,
               rx_count, rx_checksum
    );

endinterface

// File: rtl/xorexec_host_wdog.sv
// Watchdog: counts enabled cycles, flags expiry on the TIMEOUT-th cycle.
// Latency: expire is combinational from the registered count (same cycle).
// Backpressure: none; clr has priority over counting.
// Ports: clk, rst (async high), clr (restart), en (count), expire (out).
module xorexec_host_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] cnt;

    // Expiry is seen in the cycle the count sits at TIMEOUT-1, so the
    // caller aborts after exactly TIMEOUT enabled cycles.
    assign expire = en && (cnt == W'(TIMEOUT - 1));

    // Saturates at the terminal value so a caller that lingers cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xorexec_host.sv
// Host stream engine: pushes seed+i bytes into the input FIFO, drains and
// XOR-accumulates results, reports count/checksum and done/timeout status.
// Latency: first push the cycle after start is accepted; done one cycle after
// the last pop. Backpressure: push waits on ififo_not_full, pop on ofifo_rdy,
// one byte/cycle per direction otherwise; a stalled receive side aborts via
// the watchdog.
// Ports: clk, rst (async high), bus (xorexec_host_if.master).
module xorexec_host
    import xorexec_host_pkg::*;
#(
    parameter int dwidth  = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    xorexec_host_if.master bus
);

    host_state_e        state_q;
    host_state_e        state_d;
    logic [LEN_W-1:0]   len_q;
    logic [dwidth-1:0]  seed_q;
    logic [LEN_W-1:0]   tx_cnt;
    logic [LEN_W-1:0]   rx_count_q;
    logic [dwidth-1:0]  rx_csum_q;
    logic               error_q;
    logic               err_d;
    logic               accept;
    logic               push;
    logic               pop;
    logic               busy;
    logic               done;
    logic               expire;

    assign accept = (state_q == IDLE) && bus.start;

    xorexec_host_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept || pop),
        .en     (state_q == RUN),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        err_d   = error_q;
        push    = 1'b0;
        pop     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d   = 1'b0;
                    state_d = (bus.len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                push = (tx_cnt < len_q) && bus.ififo_not_full;
                pop  = (rx_count_q < len_q) && bus.ofifo_rdy;
                // A pop in the expiry cycle both completes progress and
                // restarts the watchdog, so it suppresses the abort.
                if (pop && (rx_count_q == len_q - 8'd1)) begin
                    state_d = DONE;
                end else if (expire && !pop) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            seed_q     <= '0;
            tx_cnt     <= '0;
            rx_count_q <= '0;
            rx_csum_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            error_q <= err_d;
            if (accept) begin
                len_q      <= bus.len;
                seed_q     <= bus.seed;
                tx_cnt     <= '0;
                rx_count_q <= '0;
                rx_csum_q  <= '0;
            end else begin
                if (push) begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
                if (pop) begin
                    rx_count_q <= rx_count_q + 1'b1;
                    rx_csum_q  <= rx_csum_q ^ bus.odata;
                end
            end
        end
    end

    // Byte stream wraps modulo 2^dwidth.
    assign bus.idata       = seed_q + dwidth'(tx_cnt);
    assign bus.ififo_push  = push;
    assign bus.ofifo_pop   = pop;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.error       = error_q;
    assign bus.rx_count    = rx_count_q;
    assign bus.rx_checksum = rx_csum_q;

endmodule
